// File: rtl/apb_multi_counter.sv
// ---------------------------------------------------------------------------
// apb_multi_counter
//   N_CH independent up/down counters (D_WIDTH bits each) behind an APB3
//   slave port. Each channel counts when CTRL.RUN and its hardware enable
//   are both high, and pulses a one-cycle wrap strobe on a terminal event.
//
//   Optional feature macro: CNT_IRQ_EN
//     defined   -> irq output, IRQ_STATUS (0x100, W1C) and IRQ_MASK (0x104)
//     undefined -> no irq port; 0x100/0x104 are unmapped (pslverr)
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata   APB3 request
//   prdata           read data, registered in the setup phase
//   pready           tied 1 (zero wait states)
//   pslverr          error for unmapped addresses, asserted in access phase
//   en[N_CH]         per-channel hardware count enable
//   count            channel c on [c*D_WIDTH +: D_WIDTH]
//   wrap[N_CH]       one-cycle terminal-count strobe per channel
//   irq              (CNT_IRQ_EN only) |(IRQ_STATUS & IRQ_MASK), registered
//
// Register map, channel c at c*0x10:
//   +0x0 CTRL  bit0 RUN, bit1 DOWN, bit2 SAT
//   +0x4 COUNT
//   +0x8 LIMIT (reset all-ones)
//   +0xC reads 0
// ---------------------------------------------------------------------------

// One counter channel: CTRL/COUNT/LIMIT registers plus step logic.
module apb_multi_counter_ch #(
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_ctrl_i,
  input  logic               wr_count_i,
  input  logic               wr_limit_i,
  input  logic [2:0]         ctrl_wdata_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic               en_i,
  output logic [2:0]         ctrl_o,
  output logic [D_WIDTH-1:0] count_o,
  output logic [D_WIDTH-1:0] limit_o,
  output logic               wrap_o
);
  localparam logic [D_WIDTH-1:0] ONE = D_WIDTH'(1);

  logic [2:0]         ctrl_q;
  logic [D_WIDTH-1:0] cnt_q, cnt_d, lim_q, cnt_inc, cnt_dec;
  logic               wrap_q, wrap_d;
  logic               run, down, sat;

  assign run     = ctrl_q[0];
  assign down    = ctrl_q[1];
  assign sat     = ctrl_q[2];
  assign cnt_inc = cnt_q + ONE;
  assign cnt_dec = cnt_q - ONE;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (wr_count_i) begin
      // A bus write to COUNT overrides any step in the same cycle.
      cnt_d = wdata_i;
    end else if (run && en_i) begin
      if (!down) begin
        // ">=" so a LIMIT written below the current count wraps next step.
        if (cnt_q >= lim_q) begin
          if (!sat) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_inc;
          // Saturating mode strobes only on the step that reaches LIMIT.
          wrap_d = sat && (cnt_inc == lim_q);
        end
      end else begin
        if (cnt_q == '0) begin
          if (!sat) begin
            cnt_d  = lim_q;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_dec;
          wrap_d = sat && (cnt_q == ONE);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      cnt_q  <= '0;
      lim_q  <= '1;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      if (wr_ctrl_i)  ctrl_q <= ctrl_wdata_i;
      if (wr_limit_i) lim_q  <= wdata_i;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign count_o = cnt_q;
  assign limit_o = lim_q;
  assign wrap_o  = wrap_q;
endmodule

module apb_multi_counter #(
  parameter int N_CH    = 4,
  parameter int D_WIDTH = 8,
  parameter int ADDR_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_W-1:0]       paddr,
  input  logic [31:0]             pwdata,
  output logic [31:0]             prdata,
  output logic                    pready,
  output logic                    pslverr,
  input  logic [N_CH-1:0]         en,
  output logic [N_CH*D_WIDTH-1:0] count,
  output logic [N_CH-1:0]         wrap
`ifdef CNT_IRQ_EN
  ,
  output logic                    irq
`endif
);
  // ---------------- address decode ----------------
  logic        hi_blk, ch_hit, irq_hit, addr_err;
  logic [3:0]  slot;
  logic [1:0]  reg_sel;
  logic        setup, wr_en;

  assign hi_blk  = |paddr[ADDR_W-1:8];
  assign slot    = paddr[7:4];
  assign reg_sel = paddr[3:2];
  assign ch_hit  = !hi_blk && ({28'd0, slot} < 32'(N_CH));

`ifdef CNT_IRQ_EN
  logic irq_blk, irq_stat_hit, irq_mask_hit;
  assign irq_blk      = (paddr[ADDR_W-1:8] == (ADDR_W-8)'(1));
  assign irq_stat_hit = irq_blk && (paddr[7:2] == 6'h00);
  assign irq_mask_hit = irq_blk && (paddr[7:2] == 6'h01);
  assign irq_hit      = irq_stat_hit || irq_mask_hit;
`else
  assign irq_hit      = 1'b0;
`endif

  assign addr_err = !(ch_hit || irq_hit);
  assign setup    = psel && !penable;
  // Erroring writes are dropped here, so no register ever sees them.
  assign wr_en    = psel && penable && pwrite && !addr_err;

  // ---------------- channels ----------------
  logic [N_CH-1:0][2:0]         ctrl_a;
  logic [N_CH-1:0][D_WIDTH-1:0] cnt_a, lim_a;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_en && ch_hit && (slot == 4'(c));

    apb_multi_counter_ch #(.D_WIDTH(D_WIDTH)) u_ch (
      .clk          (clk),
      .rst          (rst),
      .wr_ctrl_i    (sel && (reg_sel == 2'd0)),
      .wr_count_i   (sel && (reg_sel == 2'd1)),
      .wr_limit_i   (sel && (reg_sel == 2'd2)),
      .ctrl_wdata_i (pwdata[2:0]),
      .wdata_i      (pwdata[D_WIDTH-1:0]),
      .en_i         (en[c]),
      .ctrl_o       (ctrl_a[c]),
      .count_o      (cnt_a[c]),
      .limit_o      (lim_a[c]),
      .wrap_o       (wrap[c])
    );
  end

  assign count = cnt_a;

`ifdef CNT_IRQ_EN
  // ---------------- interrupt block ----------------
  logic [N_CH-1:0] irq_stat_q, irq_mask_q, w1c;
  logic            irq_q;

  assign w1c = (wr_en && irq_stat_hit) ? pwdata[N_CH-1:0] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_stat_q <= '0;
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      // OR-ing wrap after the clear makes a same-cycle set win.
      irq_stat_q <= (irq_stat_q & ~w1c) | wrap;
      if (wr_en && irq_mask_hit) irq_mask_q <= pwdata[N_CH-1:0];
      irq_q      <= |(irq_stat_q & irq_mask_q);
    end
  end

  assign irq = irq_q;
`endif

  // ---------------- read mux ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_hit && (slot == 4'(c))) begin
        case (reg_sel)
          2'd0:    rdata = 32'(ctrl_a[c]);
          2'd1:    rdata = 32'(cnt_a[c]);
          2'd2:    rdata = 32'(lim_a[c]);
          default: rdata = '0;
        endcase
      end
    end
`ifdef CNT_IRQ_EN
    if (irq_stat_hit) rdata = 32'(irq_stat_q);
    if (irq_mask_hit) rdata = 32'(irq_mask_q);
`endif
  end

  // ---------------- APB response ----------------
  // Data and error are captured in setup; err_q lives exactly one cycle,
  // which is the access phase of a well-formed transfer.
  logic [31:0] prdata_q;
  logic        err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= setup && addr_err;
      if (setup) prdata_q <= addr_err ? 32'd0 : rdata;
    end
  end

  assign prdata  = prdata_q;
  assign pslverr = err_q;
  assign pready  = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{paddr[1:0], pwdata};
endmodule

// File: tb/tb_apb_multi_counter.sv
module tb_apb_multi_counter;
  localparam int N_CH = 4;
  localparam int DW   = 8;
  localparam int AW   = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [31:0]       pwdata, prdata;
  logic              pready, pslverr;
  logic [N_CH-1:0]   en;
  logic [N_CH*DW-1:0] count;
  logic [N_CH-1:0]   wrap;
`ifdef CNT_IRQ_EN
  logic              irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  apb_multi_counter #(.N_CH(N_CH), .D_WIDTH(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .en      (en),
    .count   (count),
    .wrap    (wrap)
`ifdef CNT_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    else begin
      e = sb_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic apb_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic err);
    sb_q.push_back(32'(err));
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    sb_chk($sformatf("wr_err@%0h", a), 32'(pslverr));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [AW-1:0] a, input logic [31:0] exp, input logic err);
    sb_q.push_back(exp);
    sb_q.push_back(32'(err));
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    sb_chk($sformatf("rd@%0h", a), prdata);
    sb_chk($sformatf("rd_err@%0h", a), 32'(pslverr));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Expected (count, wrap) per stepped cycle must be queued by the caller.
  task automatic run_steps(input int ch, input int n, input string tag);
    en[ch] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sb_chk($sformatf("%s_cnt%0d", tag, i), 32'(count[ch*DW +: DW]));
      sb_chk($sformatf("%s_wrap%0d", tag, i), 32'(wrap[ch]));
    end
    en[ch] = 1'b0;
  endtask

  task automatic exp_step(input logic [31:0] c, input logic w);
    sb_q.push_back(c);
    sb_q.push_back(32'(w));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; en = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    chk("rst_count", count, 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    apb_rd(12'h008, 32'hFF, 1'b0);
    apb_rd(12'h004, 32'h00, 1'b0);
    apb_rd(12'h000, 32'h00, 1'b0);
    apb_rd(12'h038, 32'hFF, 1'b0);
    apb_rd(12'h00C, 32'h00, 1'b0);

    // Up wrap on ch0: LIMIT=3
    apb_wr(12'h008, 32'h3, 1'b0);
    apb_wr(12'h000, 32'h1, 1'b0);
    exp_step(1, 0); exp_step(2, 0); exp_step(3, 0); exp_step(0, 1); exp_step(1, 0);
    run_steps(0, 5, "upwrap");
    apb_rd(12'h004, 32'h1, 1'b0);

    // Gating: en low holds, RUN low holds
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("gate_en%0d", i), 32'(count[DW-1:0]), 32'h1);
    end
    apb_wr(12'h000, 32'h0, 1'b0);
    exp_step(1, 0); exp_step(1, 0);
    run_steps(0, 2, "norun");

    // Down saturate on ch1
    apb_wr(12'h014, 32'h2, 1'b0);
    apb_wr(12'h010, 32'h7, 1'b0);
    exp_step(1, 0); exp_step(0, 1); exp_step(0, 0); exp_step(0, 0);
    run_steps(1, 4, "dnsat");

    // Write to COUNT wins over a step in the same cycle
    apb_wr(12'h008, 32'hFF, 1'b0);
    apb_wr(12'h000, 32'h1, 1'b0);
    en[0] = 1'b1;
    apb_wr(12'h004, 32'h40, 1'b0);
    chk("wwin_cnt", 32'(count[DW-1:0]), 32'h40);
    chk("wwin_wrap", 32'(wrap[0]), 32'h0);
    en[0] = 1'b0;
    apb_rd(12'h004, 32'h40, 1'b0);

    // LIMIT written below current count wraps on next step
    apb_wr(12'h008, 32'h10, 1'b0);
    exp_step(0, 1);
    run_steps(0, 1, "limlow");

    // LIMIT=0, up, no saturation: stuck at 0, wrap every step
    apb_wr(12'h028, 32'h0, 1'b0);
    apb_wr(12'h020, 32'h1, 1'b0);
    exp_step(0, 1); exp_step(0, 1); exp_step(0, 1);
    run_steps(2, 3, "lim0");

    // Up saturate on ch3
    apb_wr(12'h038, 32'h2, 1'b0);
    apb_wr(12'h030, 32'h5, 1'b0);
    exp_step(1, 0); exp_step(2, 1); exp_step(2, 0); exp_step(2, 0);
    run_steps(3, 4, "upsat");

    // Down wrap (SAT=0) on ch1 from 0 reloads LIMIT
    apb_wr(12'h010, 32'h3, 1'b0);
    exp_step(32'hFF, 1); exp_step(32'hFE, 0);
    run_steps(1, 2, "dnwrap");

    // Unmapped accesses
    apb_rd(12'h040, 32'h0, 1'b1);
    apb_wr(12'h044, 32'h55, 1'b1);
    apb_rd(12'h004, 32'h0, 1'b0);
    apb_rd(12'h034, 32'h2, 1'b0);
    apb_rd(12'h200, 32'h0, 1'b1);
    apb_rd(12'hFFC, 32'h0, 1'b1);
`ifdef CNT_IRQ_EN
    apb_rd(12'h108, 32'h0, 1'b1);
`else
    apb_rd(12'h100, 32'h0, 1'b1);
    apb_wr(12'h104, 32'h1, 1'b1);
`endif

    // Reset in the middle of a write's access phase
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h038; pwdata = 32'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_count", count, 32'h0);
    chk("midrst_prdata", prdata, 32'h0);
    chk("midrst_pslverr", 32'(pslverr), 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apb_rd(12'h038, 32'hFF, 1'b0);
    apb_rd(12'h034, 32'h0, 1'b0);
    apb_rd(12'h030, 32'h0, 1'b0);

`ifdef CNT_IRQ_EN
    // Interrupt: masked ch0 wrap raises irq, W1C drops it
    chk("irq_rst", 32'(irq), 32'h0);
    apb_wr(12'h104, 32'h1, 1'b0);
    apb_rd(12'h104, 32'h1, 1'b0);
    apb_wr(12'h008, 32'h0, 1'b0);
    apb_wr(12'h000, 32'h1, 1'b0);
    exp_step(0, 1);
    run_steps(0, 1, "irqwrap");
    repeat (3) @(posedge clk);
    #1;
    chk("irq_set", 32'(irq), 32'h1);
    apb_rd(12'h100, 32'h1, 1'b0);
    apb_wr(12'h100, 32'h1, 1'b0);
    @(posedge clk); #1;
    chk("irq_clr", 32'(irq), 32'h0);
    apb_rd(12'h100, 32'h0, 1'b0);
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
